// File: rtl/segway_pkg.sv
// Shared types and constants for the segway rider/steering control path.
package segway_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    STEER
  } rider_state_t;

  localparam logic [11:0] MIN_RIDER_WT_DEF = 12'h200;
  localparam logic [11:0] WT_HYST_DEF      = 12'h040;

  localparam int unsigned TMR_W_FAST = 15;
  localparam int unsigned TMR_W_FULL = 26;

  function automatic int unsigned tmr_width(input bit fast);
    return fast ? TMR_W_FAST : TMR_W_FULL;
  endfunction

endpackage

// File: rtl/rider_seq_if.sv
// Load-cell sample inputs and rider/steering controls of the rider sequencer.
interface rider_seq_if;
  logic        ld_vld;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic        pwr_up;
  logic        rider_off;
  logic        en_steer;
  logic        tmr_full;

  modport master (
    output ld_vld, lft_ld, rght_ld, pwr_up,
    input  rider_off, en_steer, tmr_full
  );

  modport slave (
    input  ld_vld, lft_ld, rght_ld, pwr_up,
    output rider_off, en_steer, tmr_full
  );
endinterface

// File: rtl/rider_ld_eval.sv
// Combinational load-cell evaluation: total load, balance and gross-imbalance flags.
module rider_ld_eval (
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  output logic [12:0] sum,
  output logic        bal,
  output logic        gross_unbal
);

  logic [11:0] diff;

  always_comb begin
    sum         = {1'b0, lft_ld} + {1'b0, rght_ld};
    diff        = (lft_ld >= rght_ld) ? (lft_ld - rght_ld) : (rght_ld - lft_ld);
    bal         = {1'b0, diff} < (sum >> 2);
    // 15/16 of sum, compared at 13 bits
    gross_unbal = {1'b0, diff} > (sum - (sum >> 4));
  end

endmodule

// File: rtl/rider_seq.sv
// Rider-detect and steering-enable sequencer ahead of the balance controller.
module rider_seq
  import segway_pkg::*;
#(
  parameter bit          fast_sim     = 1'b1,
  parameter logic [11:0] MIN_RIDER_WT = MIN_RIDER_WT_DEF,
  parameter logic [11:0] WT_HYST      = WT_HYST_DEF
) (
  input  logic       clk,
  input  logic       rst,
  rider_seq_if.slave bus
);

  localparam int unsigned     TmrW   = tmr_width(fast_sim);
  localparam logic [12:0]     SetThr = {1'b0, MIN_RIDER_WT};
  localparam logic [12:0]     ClrThr = {1'b0, MIN_RIDER_WT - WT_HYST};
  localparam logic [TmrW-1:0] TmrOne = {{(TmrW-1){1'b0}}, 1'b1};

  logic [12:0] sum;
  logic        bal;
  logic        gross_unbal;

  rider_ld_eval u_ld_eval (
    .lft_ld      (bus.lft_ld),
    .rght_ld     (bus.rght_ld),
    .sum         (sum),
    .bal         (bal),
    .gross_unbal (gross_unbal)
  );

  rider_state_t    state_q, state_d;
  logic [TmrW-1:0] timer_q, timer_d;
  logic            pres_q, pres_d;
  logic            timer_clr;
  logic            tmr_full_q, rider_off_q, en_steer_q;
  logic            over_set, under_clr;

  assign over_set  = sum > SetThr;
  assign under_clr = sum < ClrThr;

  // Equality at either threshold holds the current presence.
  always_comb begin
    pres_d = pres_q;
    if (bus.ld_vld) begin
      if (over_set) begin
        pres_d = 1'b1;
      end else if (under_clr) begin
        pres_d = 1'b0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.ld_vld && over_set && bus.pwr_up) state_d = WAIT;
      end
      WAIT: begin
        if (!bus.pwr_up || (bus.ld_vld && !pres_d)) begin
          state_d = IDLE;
        end else if (bus.ld_vld && !bal) begin
          timer_clr = 1'b1;
        end else if (tmr_full_q && bus.ld_vld) begin
          state_d = STEER;
        end
      end
      STEER: begin
        if (!bus.pwr_up || !pres_d) begin
          state_d = IDLE;
        end else if (bus.ld_vld && gross_unbal) begin
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if ((state_d != state_q) || timer_clr) begin
      timer_d = '0;
    end else if ((state_q == WAIT) && !(&timer_q)) begin
      timer_d = timer_q + TmrOne;
    end else begin
      timer_d = timer_q;
    end
  end

  // Outputs are decoded from next-state so they move on the transition edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      pres_q      <= 1'b0;
      rider_off_q <= 1'b1;
      en_steer_q  <= 1'b0;
      tmr_full_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      pres_q      <= pres_d;
      rider_off_q <= (state_d == IDLE);
      en_steer_q  <= (state_d == STEER);
      tmr_full_q  <= &timer_d;
    end
  end

  assign bus.rider_off = rider_off_q;
  assign bus.en_steer  = en_steer_q;
  assign bus.tmr_full  = tmr_full_q;

endmodule

// File: tb/tb_rider_seq.sv
// Four parallel rider_seq instances checked every cycle against a behavioural model.
module tb_rider_seq;

  localparam int N      = 4;
  localparam int TFULL  = 32767;
  localparam int IMB_AT = 20000;
  localparam int MIN_WT = 'h200;
  localparam int HYST   = 'h040;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v [N];
  logic        vld   [N];
  logic [11:0] lft   [N];
  logic [11:0] rgt   [N];
  logic        pwr   [N];
  logic [2:0]  obs   [N];

  generate
    for (genvar g = 0; g < N; g++) begin : g_dut
      rider_seq_if bus ();
      assign bus.ld_vld  = vld[g];
      assign bus.lft_ld  = lft[g];
      assign bus.rght_ld = rgt[g];
      assign bus.pwr_up  = pwr[g];
      assign obs[g]      = {bus.rider_off, bus.en_steer, bus.tmr_full};
      rider_seq #(.fast_sim(1'b1)) u_dut (
        .clk (clk),
        .rst (rst_v[g]),
        .bus (bus)
      );
    end
  endgenerate

  // Model: 0 = no rider, 1 = settling, 2 = steering; cnt = cycles settled since last clear.
  int m_st      [N];
  int m_cnt     [N];
  bit m_pres    [N];
  int steer_cyc [N];

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] m_out(input int g);
    return {m_st[g] == 0, m_st[g] == 2, m_cnt[g] >= TFULL};
  endfunction

  function automatic void m_reset(input int g);
    m_st[g]   = 0;
    m_cnt[g]  = 0;
    m_pres[g] = 1'b0;
  endfunction

  function automatic void m_step(input int g);
    int s, d, nst;
    bit bal, gross, pres, clr;
    s     = int'(lft[g]) + int'(rgt[g]);
    d     = (lft[g] > rgt[g]) ? int'(lft[g]) - int'(rgt[g]) : int'(rgt[g]) - int'(lft[g]);
    bal   = d < s / 4;
    gross = d > s - s / 16;
    pres  = m_pres[g];
    if (vld[g]) begin
      if (s > MIN_WT) pres = 1'b1;
      else if (s < MIN_WT - HYST) pres = 1'b0;
    end
    nst = m_st[g];
    clr = 1'b0;
    case (m_st[g])
      0: if (vld[g] && s > MIN_WT && pwr[g]) nst = 1;
      1: begin
        if (!pwr[g] || (vld[g] && !pres)) nst = 0;
        else if (vld[g] && !bal) clr = 1'b1;
        else if (vld[g] && m_cnt[g] >= TFULL) nst = 2;
      end
      default: begin
        if (!pwr[g] || !pres) nst = 0;
        else if (vld[g] && gross) nst = 1;
      end
    endcase
    if (nst != m_st[g]) m_cnt[g] = 0;
    else if (m_st[g] == 1) m_cnt[g] = clr ? 0 : m_cnt[g] + 1;
    m_st[g]   = nst;
    m_pres[g] = pres;
  endfunction

  task automatic step();
    @(posedge clk);
    for (int g = 0; g < N; g++) begin
      if (rst_v[g]) m_reset(g);
      else m_step(g);
    end
    #1;
    for (int g = 0; g < N; g++) begin
      check_eq($sformatf("out%0d", g), obs[g], m_out(g));
      if (m_st[g] == 2) steer_cyc[g]++;
    end
  endtask

  task automatic quiet();
    for (int g = 0; g < N; g++) begin
      vld[g] = 1'b0;
      pwr[g] = 1'b1;
    end
  endtask

  task automatic set_ld(input int g, input logic [11:0] l, input logic [11:0] r);
    vld[g] = 1'b1;
    lft[g] = l;
    rgt[g] = r;
  endtask

  task automatic set_bal(input int g);
    int l, r;
    l = 'h140 + int'($urandom_range(0, 128));
    r = l + int'($urandom_range(0, 32)) - 16;
    set_ld(g, 12'(l), 12'(r));
  endtask

  task automatic set_rnd(input int g);
    if ($urandom_range(0, 1) == 1) begin
      lft[g] = 12'($urandom_range('h0C0, 'h130));
      rgt[g] = 12'($urandom_range('h0C0, 'h130));
    end else begin
      lft[g] = 12'($urandom);
      rgt[g] = 12'($urandom);
    end
    vld[g] = ($urandom_range(0, 3) == 0);
    pwr[g] = ($urandom_range(0, 63) != 0);
  endtask

  initial begin
    bit g1_done, g2_done, g3_done;
    int g0_rise, i;
    g1_done = 1'b0;
    g2_done = 1'b0;
    g3_done = 1'b0;
    g0_rise = -1;
    i       = 0;
    for (int g = 0; g < N; g++) begin
      rst_v[g] = 1'b0;
      lft[g] = '0;
      rgt[g] = '0;
      steer_cyc[g] = 0;
      m_reset(g);
    end
    quiet();
    #2;
    for (int g = 0; g < N; g++) rst_v[g] = 1'b1;
    #1;
    for (int g = 0; g < N; g++) check_eq("reset_val", obs[g], 3'b100);
    step();
    step();
    for (int g = 0; g < N; g++) rst_v[g] = 1'b0;
    repeat (8) step();

    for (int g = 0; g < N; g++) begin
      set_ld(g, 12'h180, 12'h180);
      pwr[g] = 1'b0;
    end
    step();
    for (int g = 0; g < N; g++) check_eq("pwr_off_idle", obs[g], 3'b100);
    quiet();
    step();

    for (int g = 0; g < N; g++) set_ld(g, 12'h180, 12'h180);
    step();
    for (int g = 0; g < N; g++) check_eq("mount", obs[g], 3'b000);

    // Instance roles: 0 imbalance restart, 1 power drop at full timer, 2 gross, 3 async reset.
    while (g0_rise < 0 && i < 60000) begin
      quiet();
      if (i == IMB_AT) set_ld(0, 12'h300, 12'h080);
      else if (i % 64 == 63) set_bal(0);
      if (!g1_done && m_cnt[1] >= TFULL + 16) begin
        check_eq("pre_simul_full", obs[1][0], 1);
        set_bal(1);
        pwr[1] = 1'b0;
      end else if (!g1_done && i < 32000 && i % 64 == 63) begin
        set_bal(1);
      end
      if (!g2_done && steer_cyc[2] >= 100) set_ld(2, 12'h3F0, 12'h000);
      else if (!g2_done && i % 64 == 63) set_bal(2);
      if (!g3_done && i % 64 == 63) set_bal(3);
      step();
      if (!pwr[1] && !g1_done) begin
        check_eq("simul_idle", obs[1], 3'b100);
        g1_done = 1'b1;
      end
      if (vld[2] && lft[2] == 12'h3F0 && !g2_done) begin
        check_eq("gross_wait", obs[2], 3'b000);
        g2_done = 1'b1;
      end
      if (obs[0][1] && g0_rise < 0) g0_rise = i;
      if (rst_v[3]) begin
        rst_v[3] = 1'b0;
      end else if (!g3_done && steer_cyc[3] >= 50) begin
        rst_v[3] = 1'b1;
        #1;
        check_eq("async_rst", obs[3], 3'b100);
        m_reset(3);
        g3_done = 1'b1;
      end
      i++;
    end

    check_eq("g0_steer_seen", g0_rise >= 0, 1);
    check_eq("imb_gap_min", (g0_rise - IMB_AT) >= TFULL + 1, 1);
    check_eq("imb_gap_max", (g0_rise - IMB_AT) < TFULL + 66, 1);

    quiet();
    set_ld(0, 12'h0E8, 12'h0E8);
    step();
    check_eq("hyst_hold", obs[0], 3'b010);
    quiet();
    repeat (4) step();
    check_eq("steer_quiet", obs[0], 3'b010);
    set_ld(0, 12'h0D8, 12'h0D8);
    step();
    check_eq("hyst_drop", obs[0], 3'b100);
    quiet();
    repeat (4) step();
    check_eq("g1_no_reentry", obs[1], 3'b100);
    check_eq("g2_wait", obs[2], 3'b000);
    check_eq("g3_hold", obs[3], 3'b100);

    repeat (3000) begin
      for (int g = 0; g < N; g++) set_rnd(g);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
